// File: rtl/if_id_fetch_stage.sv
// SPARC instruction-fetch stage with IF/ID pipeline register: PC/nPC delayed-branch sequencing,
// delay-slot annulment and stall hold. Optional perf counters when IF_PERF_COUNT_EN is defined.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        annul_ds,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] npc,
    output logic [31:0] ID_instr,
    output logic [31:0] ID_pc,
    output logic        ID_valid
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] target_aligned;

    assign target_aligned = branch_target & 32'hFFFF_FFFC;

    always_comb begin
        pc_d       = pc_q;
        npc_d      = npc_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        if (!stall) begin
            // The word at PC is the delay slot whenever a transfer sits in ID.
            id_pc_d    = pc_q;
            id_instr_d = annul_ds ? 32'h0 : imem_instr;
            id_valid_d = ~annul_ds;
            pc_d       = branch_taken ? target_aligned : npc_q;
            npc_d      = pc_d + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC_ALIGNED;
            npc_q      <= RESET_PC_ALIGNED + 32'd4;
            id_instr_q <= 32'h0;
            id_pc_q    <= 32'h0;
            id_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign npc       = npc_q;
    assign ID_instr  = id_instr_q;
    assign ID_pc     = id_pc_q;
    assign ID_valid  = id_valid_q;

`ifdef IF_PERF_COUNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    always_comb begin
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;
        if (!stall) begin
            if (annul_ds) bubble_count_d = bubble_count_q + 32'd1;
            else          fetch_count_d  = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q  <= 32'h0;
            bubble_count_q <= 32'h0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed scenarios plus randomized traffic
// against a cycle-level PC/nPC reference model.
module tb_if_id_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        annul_ds;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] npc;
    logic [31:0] ID_instr;
    logic [31:0] ID_pc;
    logic        ID_valid;
`ifdef IF_PERF_COUNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_npc, m_instr, m_idpc, m_fc, m_bc;
    logic        m_valid;

    if_id_fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .annul_ds(annul_ds),
        .imem_instr(imem_instr),
        .imem_addr(imem_addr),
        .npc(npc),
        .ID_instr(ID_instr),
        .ID_pc(ID_pc),
        .ID_valid(ID_valid)
`ifdef IF_PERF_COUNT_EN
        ,
        .fetch_count(fetch_count),
        .bubble_count(bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8200_0001;
        if (a == 32'h4) return 32'h8400_0002;
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic model_reset();
        m_pc = 32'h0; m_npc = 32'h4; m_instr = 32'h0; m_idpc = 32'h0;
        m_valid = 1'b0; m_fc = 32'h0; m_bc = 32'h0;
    endtask

    // One clock: drive inputs, take the edge, advance the model, then settle 1 time unit.
    task automatic cycle(input logic s, input logic b, input logic a, input logic [31:0] t);
        stall = s; branch_taken = b; annul_ds = a; branch_target = t;
        @(posedge clk);
        if (!s) begin
            m_idpc  = m_pc;
            m_instr = a ? 32'h0 : mem_word(m_pc);
            m_valid = !a;
            if (a) m_bc = m_bc + 1; else m_fc = m_fc + 1;
            m_pc  = b ? {t[31:2], 2'b00} : m_npc;
            m_npc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; annul_ds = 1'b0; branch_target = 32'h0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 32'h0);
        n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL reset_pre_pc: got %h want %h", imem_addr, 32'h40); end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", imem_addr, 32'h0); end
        n_checks++; if (npc !== 32'h4) begin n_fail++; $display("FAIL reset_npc: got %h want %h", npc, 32'h4); end
        n_checks++; if (ID_instr !== 32'h0) begin n_fail++; $display("FAIL reset_id_instr: got %h want 0", ID_instr); end
        n_checks++; if (ID_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", ID_pc); end
        n_checks++; if (ID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", ID_valid); end
`ifdef IF_PERF_COUNT_EN
        n_checks++; if (fetch_count !== 32'h0 || bubble_count !== 32'h0) begin n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", fetch_count, bubble_count); end
`endif
        @(posedge clk); #1;
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_hold_pc: got %h want 0", imem_addr); end
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        do_reset();
        cycle(0, 0, 0, 32'h0);
        n_checks++; if (ID_instr !== 32'h8200_0001 || ID_pc !== 32'h0 || ID_valid !== 1'b1) begin n_fail++; $display("FAIL seq_word0: got %h/%h/%b want 82000001/00000000/1", ID_instr, ID_pc, ID_valid); end
        n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq_addr1: got %h want 4", imem_addr); end
        cycle(0, 0, 0, 32'h0);
        n_checks++; if (ID_instr !== 32'h8400_0002 || ID_pc !== 32'h4) begin n_fail++; $display("FAIL seq_word1: got %h/%h want 84000002/00000004", ID_instr, ID_pc); end
        n_checks++; if (imem_addr !== 32'h8 || npc !== 32'hC) begin n_fail++; $display("FAIL seq_addr2: got %h/%h want 8/c", imem_addr, npc); end
        $display("test_sequential done");
    endtask

    task automatic test_branch(input logic annul);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 32'h0);
        n_checks++; if (imem_addr !== 32'h14 || ID_pc !== 32'h10) begin n_fail++; $display("FAIL br_setup: got %h/%h want 14/10", imem_addr, ID_pc); end
        cycle(0, 1, annul, 32'h103);
        n_checks++; if (ID_pc !== 32'h14) begin n_fail++; $display("FAIL br_ds_pc: got %h want 14", ID_pc); end
        n_checks++; if (ID_instr !== (annul ? 32'h0 : mem_word(32'h14))) begin n_fail++; $display("FAIL br_ds_instr: got %h want %h", ID_instr, annul ? 32'h0 : mem_word(32'h14)); end
        n_checks++; if (ID_valid !== !annul) begin n_fail++; $display("FAIL br_ds_valid: got %b want %b", ID_valid, !annul); end
        n_checks++; if (imem_addr !== 32'h100 || npc !== 32'h104) begin n_fail++; $display("FAIL br_target: got %h/%h want 100/104", imem_addr, npc); end
`ifdef IF_PERF_COUNT_EN
        n_checks++; if (bubble_count !== (annul ? 32'd1 : 32'd0) || fetch_count !== (annul ? 32'd5 : 32'd6)) begin n_fail++; $display("FAIL br_counters: got %0d/%0d want %0d/%0d", fetch_count, bubble_count, annul ? 5 : 6, annul ? 1 : 0); end
`endif
        cycle(0, 0, 0, 32'h0);
        n_checks++; if (ID_pc !== 32'h100 || ID_instr !== mem_word(32'h100) || imem_addr !== 32'h104) begin n_fail++; $display("FAIL br_fetch_target: got %h/%h/%h want 100/%h/104", ID_pc, ID_instr, imem_addr, mem_word(32'h100)); end
        $display("test_branch annul=%0b done", annul);
    endtask

    task automatic test_stall();
        logic [31:0] s_pc, s_npc, s_instr, s_idpc;
        logic        s_valid;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0);
        s_pc = imem_addr; s_npc = npc; s_instr = ID_instr; s_idpc = ID_pc; s_valid = ID_valid;
        for (int i = 0; i < 3; i++) begin
            cycle(1, (i == 1), (i == 2), 32'h200);
            n_checks++; if (imem_addr !== 32'hC || npc !== 32'h10) begin n_fail++; $display("FAIL stall_pc%0d: got %h/%h want c/10", i, imem_addr, npc); end
            n_checks++; if (ID_instr !== s_instr || ID_pc !== s_idpc || ID_valid !== s_valid) begin n_fail++; $display("FAIL stall_id%0d: got %h/%h/%b want %h/%h/%b", i, ID_instr, ID_pc, ID_valid, s_instr, s_idpc, s_valid); end
        end
        cycle(0, 0, 0, 32'h200);
        n_checks++; if (imem_addr !== s_npc || ID_pc !== s_pc) begin n_fail++; $display("FAIL stall_release: got %h/%h want %h/%h", imem_addr, ID_pc, s_npc, s_pc); end
        cycle(0, 1, 0, 32'h200);
        n_checks++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL stall_redirect: got %h want 200", imem_addr); end
        $display("test_stall done");
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'hFFFF_FFF8; exp_seq[1] = 32'hFFFF_FFFC; exp_seq[2] = 32'h0; exp_seq[3] = 32'h4;
        do_reset();
        cycle(0, 1, 0, 32'hFFFF_FFFB);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (imem_addr !== exp_seq[i]) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, imem_addr, exp_seq[i]); end
            cycle(0, 0, 0, 32'h0);
        end
        n_checks++; if (ID_pc !== 32'h4 || ID_instr !== 32'h8400_0002) begin n_fail++; $display("FAIL wrap_id: got %h/%h want 4/84000002", ID_pc, ID_instr); end
        $display("test_wrap done");
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_fail;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(3) == 0), ($urandom_range(4) == 0), ($urandom_range(6) == 0), $urandom);
            n_checks++;
            if (imem_addr !== m_pc || npc !== m_npc || ID_instr !== m_instr || ID_pc !== m_idpc || ID_valid !== m_valid) begin
                n_fail++;
                $display("FAIL rand%0d: got pc=%h npc=%h ins=%h idpc=%h v=%b want pc=%h npc=%h ins=%h idpc=%h v=%b",
                         i, imem_addr, npc, ID_instr, ID_pc, ID_valid, m_pc, m_npc, m_instr, m_idpc, m_valid);
            end
`ifdef IF_PERF_COUNT_EN
            n_checks++;
            if (fetch_count !== m_fc || bubble_count !== m_bc) begin
                n_fail++;
                $display("FAIL rand_cnt%0d: got %0d/%0d want %0d/%0d", i, fetch_count, bubble_count, m_fc, m_bc);
            end
`endif
        end
        $display("test_random done, %0d new errors", n_fail - errs_before);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; annul_ds = 1'b0; branch_target = 32'h0;
        model_reset();
        test_reset();
        test_sequential();
        test_branch(1'b0);
        test_branch(1'b1);
        test_stall();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
